// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- read-domain controller of the asynchronous FIFO.
//
// Owns the read pointer (binary and Gray), issues reads to the dual-port RAM
// (1-cycle read latency) and presents words through a first-word-fall-through
// valid/ready port backed by a 2-entry output stage (dout slot + skid slot),
// so one word per cycle is sustained. Also publishes empty, level and
// almost-empty status for read-side logic.
//
// Ports:
//   rclk, rrst_n   read clock, asynchronous active-low reset
//   rq2_wptr       Gray write pointer, already synchronized into rclk
//   rptr           registered Gray read pointer for the write-domain sync
//   raddr, ren     RAM read address / enable; mem_rdata valid one cycle later
//   mem_rdata      RAM read data
//   dout, dout_valid, dout_ready   FWFT output handshake
//   rempty         registered; RAM holds no unread word
//   rlevel         registered count of unread words in RAM (excludes stage)
//   almost_empty   registered; rlevel <= AE_THRESH
module fifo_rd_ctrl #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                ren,
  input  logic [DSIZE-1:0]    mem_rdata,
  output logic [DSIZE-1:0]    dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                almost_empty
);

  localparam int unsigned        PW     = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0]  AE_LIM = PW'(AE_THRESH);

  // Output-stage occupancy states (dout slot + skid slot + word in flight).
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rptr;
  logic              r_rempty;
  logic [ADDRSIZE:0] r_rlevel;
  logic              r_almost_empty;

  logic [DSIZE-1:0]  r_dout;
  logic              r_dout_valid;
  logic [DSIZE-1:0]  r_skid;
  logic              r_skid_valid;
  logic              r_inflight;

  logic [ADDRSIZE:0] w_rbinnext;
  logic [ADDRSIZE:0] w_rgraynext;
  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_level_next;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_left;
  logic              w_pop;
  logic              w_ren;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_wbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign w_occ      = {1'b0, r_dout_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  assign w_pop      = r_dout_valid & dout_ready;
  assign w_occ_left = w_occ - {1'b0, w_pop};
  // Only read when the word it returns is guaranteed a slot next cycle.
  assign w_ren      = ~r_rempty & (w_occ_left != OCC_TWO);

  assign w_rbinnext   = r_rbin + {{ADDRSIZE{1'b0}}, w_ren};
  assign w_rgraynext  = w_rbinnext ^ (w_rbinnext >> 1);
  assign w_level_next = w_wbin - w_rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin         <= '0;
      r_rptr         <= '0;
      r_rempty       <= 1'b1;
      r_rlevel       <= '0;
      r_almost_empty <= 1'b1;
    end else begin
      r_rbin         <= w_rbinnext;
      r_rptr         <= w_rgraynext;
      r_rempty       <= (w_rgraynext == rq2_wptr);
      r_rlevel       <= w_level_next;
      r_almost_empty <= (w_level_next <= AE_LIM);
    end
  end

  // Stage routing keyed on occupancy. With occ capped at 2, a valid skid
  // implies no word in flight, so the returning word and a skid shift never
  // collide; ordering is skid (older) before the in-flight word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      case (w_occ)
        OCC_EMPTY: ;
        OCC_ONE: begin
          if (r_inflight) begin
            r_dout       <= mem_rdata;
            r_dout_valid <= 1'b1;
          end else if (w_pop) begin
            r_dout_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (r_skid_valid) begin
            if (w_pop) begin
              r_dout       <= r_skid;
              r_skid_valid <= 1'b0;
            end
          end else if (w_pop) begin
            r_dout <= mem_rdata;
          end else begin
            r_skid       <= mem_rdata;
            r_skid_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rptr         = r_rptr;
  assign raddr        = r_rbin[ADDRSIZE-1:0];
  assign ren          = w_ren;
  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign rempty       = r_rempty;
  assign rlevel       = r_rlevel;
  assign almost_empty = r_almost_empty;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus a randomized run against
// a queue-based model of the read side (words read, words delivered).
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;
  logic [PW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          rempty;
  logic [PW-1:0] rlevel;
  logic          almost_empty;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wq [$];
  int            vectors = 0;
  int            miscompares = 0;
  int            wbin = 0;

  fifo_rd_ctrl #(.ADDRSIZE(AW), .DSIZE(DW), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rptr(rptr),
    .raddr(raddr), .ren(ren), .mem_rdata(mem_rdata), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .rempty(rempty),
    .rlevel(rlevel), .almost_empty(almost_empty)
  );

  always #5 rclk = ~rclk;

  // RAM with one cycle of read latency.
  always @(posedge rclk) if (ren) mem_rdata <= mem[raddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin % DEPTH] = d;
    wq.push_back(d);
    wbin++;
    rq2_wptr = gray(wbin);
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    rq2_wptr = '0;
    wbin = 0;
    wq.delete();
    dout_ready = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk) rrst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (dout_valid && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() == 0) done = 1;
      tick();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d words left expected 0", wq.size());
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    rq2_wptr = '0;
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) rrst_n = 1'b1;
      @(negedge rclk);
      vectors++;
      if ({rempty, ren, dout_valid, rlevel, almost_empty} !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset_state cycle %0d: got empty=%b ren=%b dv=%b lvl=%0d ae=%b expected 1 0 0 0 1",
                 i, rempty, ren, dout_valid, rlevel, almost_empty);
      end
    end
    tick();
  endtask

  task automatic test_single_word(input bit do_reset);
    if (do_reset) apply_reset();
    write_word(8'hA5);
    #1;
    vectors++;
    if (ren !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ren_early: got ren=%b expected 0", ren);
    end
    tick(); #1;
    vectors++;
    if ({ren, raddr, rempty, rlevel} !== {1'b1, 4'd0, 1'b0, 5'd1}) begin
      miscompares++;
      $display("FAIL single_read: got ren=%b raddr=%0d empty=%b lvl=%0d expected 1 0 0 1",
               ren, raddr, rempty, rlevel);
    end
    tick(); #1;
    vectors++;
    if ({ren, dout_valid, rempty, rlevel, rptr} !== {1'b0, 1'b0, 1'b1, 5'd0, 5'b00001}) begin
      miscompares++;
      $display("FAIL single_after_read: got ren=%b dv=%b empty=%b lvl=%0d rptr=%b expected 0 0 1 0 00001",
               ren, dout_valid, rempty, rlevel, rptr);
    end
    tick(); #1;
    vectors++;
    if ({dout_valid, dout} !== {1'b1, 8'hA5}) begin
      miscompares++;
      $display("FAIL single_data: got dv=%b dout=%h expected 1 a5", dout_valid, dout);
    end
    tick(); #1;
    vectors++;
    if ({dout_valid, rempty, rlevel} !== {1'b0, 1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL single_popped: got dv=%b empty=%b lvl=%0d expected 0 1 0", dout_valid, rempty, rlevel);
    end
    wq.delete();
    tick();
  endtask

  task automatic test_stream16();
    int ren_first, ren_cnt, dv_first, dv_cnt, next_addr;
    logic [DW-1:0] exp;
    ren_first = -1; ren_cnt = 0; dv_first = -1; dv_cnt = 0; next_addr = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) write_word(DW'($urandom));
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ren) begin
        if (ren_first < 0) ren_first = c;
        ren_cnt++;
        vectors++;
        if (raddr !== AW'(next_addr)) begin
          miscompares++;
          $display("FAIL stream_raddr: got %0d expected %0d", raddr, next_addr);
        end
        next_addr++;
      end
      if (dout_valid) begin
        if (dv_first < 0) dv_first = c;
        dv_cnt++;
        exp = (wq.size() > 0) ? wq.pop_front() : 'x;
        vectors++;
        if (dout !== exp) begin
          miscompares++;
          $display("FAIL stream_data: got %h expected %h", dout, exp);
        end
      end
      tick();
    end
    vectors++;
    if (ren_cnt != 16 || dv_cnt != 16 || dv_first - ren_first != 2) begin
      miscompares++;
      $display("FAIL stream_counts: got reads=%0d words=%0d lag=%0d expected 16 16 2",
               ren_cnt, dv_cnt, dv_first - ren_first);
    end
    #1;
    vectors++;
    if ({rptr, rempty} !== {5'b11000, 1'b1}) begin
      miscompares++;
      $display("FAIL stream_final: got rptr=%b empty=%b expected 11000 1", rptr, rempty);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int nren, pops, first_pop, last_pop;
    logic [DW-1:0] w0, exp;
    nren = 0; pops = 0; first_pop = -1; last_pop = -1;
    apply_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(DW'($urandom));
    w0 = wq[0];
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ren) nren++;
      if (i >= 3) begin
        vectors++;
        if ({dout_valid, dout} !== {1'b1, w0}) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got dv=%b dout=%h expected 1 %h", i, dout_valid, dout, w0);
        end
      end
      tick();
    end
    vectors++;
    if (nren != 2) begin
      miscompares++;
      $display("FAIL bp_reads: got %0d expected 2", nren);
    end
    dout_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dout_valid) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
        exp = (wq.size() > 0) ? wq.pop_front() : 'x;
        vectors++;
        if (dout !== exp) begin
          miscompares++;
          $display("FAIL bp_data: got %h expected %h", dout, exp);
        end
      end
      tick();
    end
    vectors++;
    if (pops != 8 || first_pop != 0 || last_pop != 7) begin
      miscompares++;
      $display("FAIL bp_release: got pops=%0d first=%0d last=%0d expected 8 0 7", pops, first_pop, last_pop);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [4];
    logic [PW-1:0] eg [4];
    logic [DW-1:0] exp;
    int k;
    ea = '{4'd14, 4'd15, 4'd0, 4'd1};
    eg = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
    k = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) write_word(DW'($urandom));
    drain();
    for (int i = 0; i < 14; i++) write_word(DW'($urandom));
    drain();
    for (int i = 0; i < 4; i++) write_word(DW'($urandom));
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ren) begin
        vectors++;
        if (k >= 4 || {raddr, rptr} !== {ea[k], eg[k]}) begin
          miscompares++;
          $display("FAIL wrap_read %0d: got raddr=%0d rptr=%b expected %0d %b",
                   k, raddr, rptr, ea[k % 4], eg[k % 4]);
        end
        k++;
      end
      if (c >= 1 && c <= 5) begin
        vectors++;
        if (rlevel !== PW'(5 - c)) begin
          miscompares++;
          $display("FAIL wrap_level cycle %0d: got %0d expected %0d", c, rlevel, 5 - c);
        end
      end
      if (dout_valid) begin
        exp = (wq.size() > 0) ? wq.pop_front() : 'x;
        vectors++;
        if (dout !== exp) begin
          miscompares++;
          $display("FAIL wrap_data: got %h expected %h", dout, exp);
        end
      end
      tick();
    end
    vectors++;
    if (k != 4 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_count: got reads=%0d left=%0d expected 4 0", k, wq.size());
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 7; i++) write_word(DW'($urandom));
    for (int i = 0; i < 5; i++) begin
      #1;
      tick();
    end
    #1;
    vectors++;
    if ({rlevel, ren, dout_valid} !== {5'd5, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midop_pre: got lvl=%0d ren=%b dv=%b expected 5 0 1", rlevel, ren, dout_valid);
    end
    #2;
    rrst_n = 1'b0;
    rq2_wptr = '0;
    wbin = 0;
    wq.delete();
    dout_ready = 1'b1;
    #1;
    vectors++;
    if ({rempty, ren, dout_valid, rlevel, almost_empty, rptr, raddr, dout} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 4'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL midop_async: got empty=%b ren=%b dv=%b lvl=%0d ae=%b rptr=%b raddr=%0d dout=%h expected 1 0 0 0 1 0 0 0",
               rempty, ren, dout_valid, rlevel, almost_empty, rptr, raddr, dout);
    end
    repeat (2) @(posedge rclk);
    @(negedge rclk) rrst_n = 1'b1;
    tick();
    test_single_word(1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] stage [$];
    logic [DW-1:0] exp;
    int  m_rd, m_wedge, m_landed, m_avail, mode, wprob, rprob;
    bit  m_infl, m_valid, m_pop, m_ren;
    m_rd = 0; m_wedge = 0; m_landed = 0; m_infl = 0; mode = 0; wprob = 50; rprob = 75;
    apply_reset();
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) begin
        mode = $urandom_range(0, 2);
        wprob = (mode == 1) ? 90 : (mode == 2) ? 20 : 50;
        rprob = (mode == 1) ? 30 : (mode == 2) ? 95 : 75;
      end
      dout_ready = ($urandom_range(0, 99) < rprob);
      if ($urandom_range(0, 99) < wprob && (wbin - m_rd) < DEPTH) write_word(DW'($urandom));
      #1;
      m_avail = m_wedge - m_rd;
      m_valid = (m_landed > 0);
      m_pop   = m_valid && dout_ready;
      m_ren   = (m_avail != 0) && ((stage.size() - (m_pop ? 1 : 0)) < 2);
      vectors++;
      if ({ren, dout_valid} !== {m_ren, m_valid}) begin
        miscompares++;
        $display("FAIL rand_handshake cycle %0d: got ren=%b dv=%b expected %b %b", c, ren, dout_valid, m_ren, m_valid);
      end
      vectors++;
      if ({rempty, almost_empty, rlevel, rptr} !== {m_avail == 0, m_avail <= 2, PW'(m_avail), gray(m_rd)}) begin
        miscompares++;
        $display("FAIL rand_status cycle %0d: got empty=%b ae=%b lvl=%0d rptr=%b expected %b %b %0d %b",
                 c, rempty, almost_empty, rlevel, rptr, m_avail == 0, m_avail <= 2, m_avail, gray(m_rd));
      end
      if (m_ren) begin
        vectors++;
        if (raddr !== AW'(m_rd)) begin
          miscompares++;
          $display("FAIL rand_raddr cycle %0d: got %0d expected %0d", c, raddr, m_rd % DEPTH);
        end
      end
      if (m_pop) begin
        exp = wq.pop_front();
        vectors++;
        if (dout !== exp || stage[0] !== exp) begin
          miscompares++;
          $display("FAIL rand_data cycle %0d: got %h expected %h", c, dout, exp);
        end
      end
      @(posedge rclk);
      if (m_pop) begin
        void'(stage.pop_front());
        m_landed--;
      end
      if (m_infl) m_landed++;
      if (m_ren) begin
        stage.push_back(mem[m_rd % DEPTH]);
        m_rd++;
      end
      m_infl  = m_ren;
      m_wedge = wbin;
      #1;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_word(1'b1);
    test_stream16();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
